hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB).
- Generates PC and IF/ID write enables and per-stage flushes for load-use stalls, taken branches and jumps.
- Generates EX-stage operand forwarding selects.
- Sequences the multi-cycle multiply/divide unit so HI/LO consumers wait for the result.
- Provides stall and flush event counters for debug.

Parameters:
MUL_LAT, 4, cycles from EX issue of MULT/MULTU until HI/LO are valid
DIV_LAT, 32, cycles from EX issue of DIV/DIVU until HI/LO are valid
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
en  in  1  pipeline enable; 0 freezes the block
id_rs_addr  in  5  rs field of the instruction in ID
id_rt_addr  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_uses_hilo  in  1  ID instruction reads HI/LO or is a mult/div
id_Jump  in  1  jump decoded in ID
ex_rs_addr  in  5  rs address of the instruction in EX
ex_rt_addr  in  5  rt address of the instruction in EX
ex_MemRead  in  1  EX instruction is a load
ex_Regs_waddr  in  5  destination register of the EX instruction
ex_muldiv_start  in  1  mult/div present in EX
ex_is_div  in  1  EX mult/div is a divide
mem_RegWrite  in  1  EX/MEM stage writes a register
mem_Regs_waddr  in  5  EX/MEM destination register
mem_Zero_Branch  in  1  taken branch resolved in MEM
wb_RegWrite  in  1  MEM/WB stage writes a register
wb_Regs_waddr  in  5  MEM/WB destination register
pc_we  out  1  PC write enable
if_id_we  out  1  IF/ID write enable
if_id_flush  out  1  clear IF/ID to a NOP
id_ex_flush  out  1  clear ID/EX control signals
ex_mem_flush  out  1  clear EX/MEM control signals
fwd_a  out  2  ALU A source: 00 = register file, 01 = MEM/WB, 10 = EX/MEM
fwd_b  out  2  ALU B source (register path), same encoding as fwd_a
muldiv_busy  out  1  HI/LO result pending
stall_cycles  out  CNT_W  number of cycles with pc_we=0 while en=1
flush_events  out  CNT_W  number of cycles with a branch or jump flush

Behaviour:
- Reset (asynchronous): state=RUN, busy counter=0, both perf counters=0.
  - Control outputs while reset is asserted: pc_we=1, if_id_we=1, all flushes=0, fwd_a=fwd_b=00, muldiv_busy=0.
  - Reset asserted mid-divide aborts the divide immediately.
- Forwarding is combinational for each EX operand (rs→fwd_a, rt→fwd_b):
  - Select 10 if mem_RegWrite and mem_Regs_waddr equals the operand address and is not 0.
  - Otherwise select 01 if the same conditions hold for the wb_* signals.
  - Otherwise select 00.
  - EX/MEM takes priority over MEM/WB. Register 0 is never forwarded.
- Load-use hazard (load_use) is asserted when all of the following hold:
  - ex_MemRead=1 and ex_Regs_waddr is not 0;
  - either (id_uses_rs and id_rs_addr equals ex_Regs_waddr) or (id_uses_rt and id_rt_addr equals ex_Regs_waddr).
- HI/LO hazard (hilo_wait) = id_uses_hilo and (muldiv_busy, or ex_muldiv_start in the same cycle).
- Stall action: pc_we=0, if_id_we=0, id_ex_flush=1 (inserts a bubble).
- Output priority, combinational, evaluated each cycle:
  1. en=0: pc_we=0, if_id_we=0, all flushes=0; FSM, busy counter and perf counters hold.
  2. mem_Zero_Branch: if_id_flush, id_ex_flush and ex_mem_flush all =1; pc_we=1; if_id_we=1; load_use and hilo_wait are ignored.
  3. load_use or hilo_wait: stall action.
  4. id_Jump: if_id_flush=1; pc_we=1.
  5. Otherwise: pc_we=1, if_id_we=1, no flushes.
- FSM (updates only when en=1):
  - RUN → BUSY when ex_muldiv_start=1 and mem_Zero_Branch=0.
    - On entry, busy counter = (ex_is_div ? DIV_LAT : MUL_LAT) - 1.
    - When mem_Zero_Branch=1 the EX mult/div is younger than the branch, so the start is suppressed.
  - BUSY: counter decrements by 1 per cycle; BUSY → RUN when the counter is 0.
    - A branch flush does not abort BUSY, because the in-flight op is older than the branch.
  - muldiv_busy = (state == BUSY).
  - A second start cannot occur while BUSY, because hilo_wait holds the next mult/div in ID.
- Counters (when en=1; wrap at 2^CNT_W):
  - stall_cycles increments on every cycle with pc_we=0.
  - flush_events increments on every cycle with if_id_flush=1.
- Counter and FSM state are registered. The forwarding, stall and flush outputs have zero-cycle latency.
- Same-cycle WB-write to ID-read bypass is outside this block's scope.

Decomposition:
- Shared package holds:
  - forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state encoding ST_RUN, ST_BUSY;
  - NOP instruction constant 32'h0000_0000.
- One sub-module, fwd_sel: computes one operand's 2-bit select from its address and the mem/wb write ports. It is instantiated twice, once for A and once for B.

Test Plan:
- Load-use: `lw $2,0($0)` in EX, `add $3,$2,$1` in ID → exactly one cycle with pc_we=0, if_id_we=0, id_ex_flush=1; the next cycle has fwd_a=01; stall_cycles=1.
- Forward priority: mem_Regs_waddr=wb_Regs_waddr=5, both RegWrite=1, ex_rs_addr=5 → fwd_a=10. With waddr=0 on both stages → fwd_a=00.
- Divide: ex_muldiv_start=1 with ex_is_div=1, then MFLO in ID the next cycle → muldiv_busy high for 32 cycles; pc_we=0 while busy; the stall releases the cycle after busy clears.
- Branch in MEM with ex_muldiv_start=1 in the same cycle → all three flushes =1, FSM stays in RUN, flush_events increments by 1.
- Branch in MEM while load_use is true → flushes asserted, pc_we=1, no stall.
- Reset asserted mid-divide at cycle 10 → muldiv_busy=0 and both counters=0 immediately; after release the block is in RUN with all enables high.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, FSM states
// and the NOP word used when a pipeline register is cleared.
package hazard_ctrl_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {ST_RUN = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// One EX operand's forwarding select. The EX/MEM result is younger than the
// MEM/WB one, so it wins. Register 0 is never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] addr,
  input  logic       mem_we,
  input  logic [4:0] mem_waddr,
  input  logic       wb_we,
  input  logic [4:0] wb_waddr,
  output logic [1:0] sel
);
  always_comb begin
    sel = FWD_RF;
    if (mem_we && (mem_waddr != 5'd0) && (mem_waddr == addr))
      sel = FWD_MEM;
    else if (wb_we && (wb_waddr != 5'd0) && (wb_waddr == addr))
      sel = FWD_WB;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: stalls, flushes, operand
// forwarding, mult/div sequencing and debug event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_uses_hilo,
  input  logic             id_Jump,
  input  logic [4:0]       ex_rs_addr,
  input  logic [4:0]       ex_rt_addr,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_Regs_waddr,
  input  logic             ex_muldiv_start,
  input  logic             ex_is_div,
  input  logic             mem_RegWrite,
  input  logic [4:0]       mem_Regs_waddr,
  input  logic             mem_Zero_Branch,
  input  logic             wb_RegWrite,
  input  logic [4:0]       wb_Regs_waddr,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  localparam int LAT_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int BW      = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;

  state_t        state, state_n;
  logic [BW-1:0] cnt, cnt_n, lat_m1;
  logic [1:0]    sel_a, sel_b;
  logic          load_use, hilo_wait;

  fwd_sel u_fwd_a (
    .addr(ex_rs_addr), .mem_we(mem_RegWrite), .mem_waddr(mem_Regs_waddr),
    .wb_we(wb_RegWrite), .wb_waddr(wb_Regs_waddr), .sel(sel_a)
  );
  fwd_sel u_fwd_b (
    .addr(ex_rt_addr), .mem_we(mem_RegWrite), .mem_waddr(mem_Regs_waddr),
    .wb_we(wb_RegWrite), .wb_waddr(wb_Regs_waddr), .sel(sel_b)
  );

  assign fwd_a       = reset_n ? sel_a : FWD_RF;
  assign fwd_b       = reset_n ? sel_b : FWD_RF;
  assign muldiv_busy = (state == ST_BUSY);

  assign load_use  = ex_MemRead && (ex_Regs_waddr != 5'd0) &&
                     ((id_uses_rs && (id_rs_addr == ex_Regs_waddr)) ||
                      (id_uses_rt && (id_rt_addr == ex_Regs_waddr)));
  assign hilo_wait = id_uses_hilo && (muldiv_busy || ex_muldiv_start);
  assign lat_m1    = ex_is_div ? BW'(DIV_LAT - 1) : BW'(MUL_LAT - 1);

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!reset_n) begin
      // hold the pass-through defaults while in reset
    end else if (!en) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
    end else if (mem_Zero_Branch) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use || hilo_wait) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (id_Jump) begin
      if_id_flush = 1'b1;
    end
  end

  // A mult/div behind a taken branch is squashed, so it never starts.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_RUN:
        if (ex_muldiv_start && !mem_Zero_Branch) begin
          state_n = ST_BUSY;
          cnt_n   = lat_m1;
        end
      ST_BUSY:
        if (cnt == '0) state_n = ST_RUN;
        else           cnt_n   = cnt - 1'b1;
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_RUN;
      cnt          <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (en) begin
      state <= state_n;
      cnt   <= cnt_n;
      if (!pc_we)      stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush) flush_events <= flush_events + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-count reference model.
module tb_hazard_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0, reset_n, en;
  logic [4:0] id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_Regs_waddr;
  logic [4:0] mem_Regs_waddr, wb_Regs_waddr;
  logic id_uses_rs, id_uses_rt, id_uses_hilo, id_Jump, ex_MemRead;
  logic ex_muldiv_start, ex_is_div, mem_RegWrite, mem_Zero_Branch, wb_RegWrite;
  logic pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int checks = 0, errors = 0;
  int pend = 0;                       // busy cycles still to come
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;

  hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_uses_hilo(id_uses_hilo), .id_Jump(id_Jump),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
    .ex_MemRead(ex_MemRead), .ex_Regs_waddr(ex_Regs_waddr),
    .ex_muldiv_start(ex_muldiv_start), .ex_is_div(ex_is_div),
    .mem_RegWrite(mem_RegWrite), .mem_Regs_waddr(mem_Regs_waddr),
    .mem_Zero_Branch(mem_Zero_Branch),
    .wb_RegWrite(wb_RegWrite), .wb_Regs_waddr(wb_Regs_waddr),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .muldiv_busy(muldiv_busy),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] m_fwd(input logic [4:0] a);
    if (!reset_n || a == 0) return 2'd0;
    if (mem_RegWrite && mem_Regs_waddr == a) return 2'd2;
    if (wb_RegWrite && wb_Regs_waddr == a) return 2'd1;
    return 2'd0;
  endfunction

  // Expected control vector {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush}
  function automatic logic [4:0] m_ctrl();
    logic lu, hw;
    lu = ex_MemRead && ex_Regs_waddr != 0 &&
         ((id_uses_rs && id_rs_addr == ex_Regs_waddr) ||
          (id_uses_rt && id_rt_addr == ex_Regs_waddr));
    hw = id_uses_hilo && (pend > 0 || ex_muldiv_start);
    if (!reset_n)        return 5'b11000;
    if (!en)             return 5'b00000;
    if (mem_Zero_Branch) return 5'b11111;
    if (lu || hw)        return 5'b00010;
    if (id_Jump)         return 5'b11100;
    return 5'b11000;
  endfunction

  // Advance the model by one clock, then move to the next falling edge.
  task automatic tick();
    logic [4:0] c;
    c = m_ctrl();
    if (reset_n && en) begin
      if (!c[4]) m_stall = m_stall + 1;
      if (c[2])  m_flush = m_flush + 1;
      if (pend > 0) pend = pend - 1;
      else if (ex_muldiv_start && !mem_Zero_Branch) pend = ex_is_div ? 32 : 4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    en = 1; id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_uses_hilo = 0; id_Jump = 0; ex_rs_addr = 0; ex_rt_addr = 0;
    ex_MemRead = 0; ex_Regs_waddr = 0; ex_muldiv_start = 0; ex_is_div = 0;
    mem_RegWrite = 0; mem_Regs_waddr = 0; mem_Zero_Branch = 0;
    wb_RegWrite = 0; wb_Regs_waddr = 0;
  endtask

  task automatic test_reset();
    idle(); reset_n = 0;
    mem_RegWrite = 1; mem_Regs_waddr = 7; ex_rs_addr = 7; mem_Zero_Branch = 1;
    #1;
    checks++; if ({pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush} !== 5'b11000) begin
      errors++; $display("FAIL reset_ctrl got %b want 11000", {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush}); end
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL reset_fwd got %b/%b want 00/00", fwd_a, fwd_b); end
    checks++; if (muldiv_busy !== 0 || stall_cycles !== 0 || flush_events !== 0) begin
      errors++; $display("FAIL reset_state busy %b stall %0d flush %0d want 0", muldiv_busy, stall_cycles, flush_events); end
    @(negedge clk); idle(); reset_n = 1; @(negedge clk);
  endtask

  task automatic test_fwd_priority();
    idle();
    mem_RegWrite = 1; wb_RegWrite = 1; mem_Regs_waddr = 5; wb_Regs_waddr = 5;
    ex_rs_addr = 5; ex_rt_addr = 5; #1;
    checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
      errors++; $display("FAIL fwd_mem_prio got %b/%b want 10/10", fwd_a, fwd_b); end
    mem_Regs_waddr = 6; #1;
    checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_wb got %b want 01", fwd_a); end
    mem_Regs_waddr = 0; wb_Regs_waddr = 0; ex_rs_addr = 0; ex_rt_addr = 0; #1;
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL fwd_r0 got %b/%b want 00/00", fwd_a, fwd_b); end
    tick();
  endtask

  task automatic test_load_use();
    logic [CNT_W-1:0] s0;
    s0 = m_stall;
    idle();  // lw $2,0($0) in EX ; add $3,$2,$1 in ID
    ex_MemRead = 1; ex_Regs_waddr = 2; id_rs_addr = 2; id_rt_addr = 1;
    id_uses_rs = 1; id_uses_rt = 1; #1;
    checks++; if ({pc_we, if_id_we, id_ex_flush} !== 3'b001) begin
      errors++; $display("FAIL load_use_stall got %b want 001", {pc_we, if_id_we, id_ex_flush}); end
    tick();
    idle(); mem_RegWrite = 1; mem_Regs_waddr = 2;
    id_rs_addr = 2; id_rt_addr = 1; id_uses_rs = 1; id_uses_rt = 1; #1;
    checks++; if (pc_we !== 1 || id_ex_flush !== 0) begin
      errors++; $display("FAIL load_use_release pc_we %b flush %b want 1 0", pc_we, id_ex_flush); end
    tick();
    idle(); ex_rs_addr = 2; ex_rt_addr = 1; wb_RegWrite = 1; wb_Regs_waddr = 2; #1;
    checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL load_use_fwd got %b/%b want 01/00", fwd_a, fwd_b); end
    checks++; if (stall_cycles !== s0 + 1) begin
      errors++; $display("FAIL load_use_count got %0d want %0d", stall_cycles, s0 + 1); end
    tick();
  endtask

  task automatic test_divide();
    idle(); ex_muldiv_start = 1; ex_is_div = 1; #1;
    checks++; if (muldiv_busy !== 0 || pc_we !== 1) begin
      errors++; $display("FAIL div_issue busy %b pc_we %b want 0 1", muldiv_busy, pc_we); end
    tick();
    idle(); id_uses_hilo = 1;  // MFLO waits in ID
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++; if (muldiv_busy !== 1 || pc_we !== 0) begin
        errors++; $display("FAIL div_busy cycle %0d busy %b pc_we %b want 1 0", i, muldiv_busy, pc_we); end
      tick();
    end
    #1;
    checks++; if (muldiv_busy !== 0 || pc_we !== 1 || if_id_we !== 1) begin
      errors++; $display("FAIL div_done busy %b pc_we %b if_id_we %b want 0 1 1", muldiv_busy, pc_we, if_id_we); end
    tick();
  endtask

  task automatic test_branch();
    logic [CNT_W-1:0] f0, s0;
    f0 = m_flush; s0 = m_stall;
    idle(); mem_Zero_Branch = 1; ex_muldiv_start = 1;
    ex_MemRead = 1; ex_Regs_waddr = 4; id_rs_addr = 4; id_uses_rs = 1; #1;
    checks++; if ({pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush} !== 5'b11111) begin
      errors++; $display("FAIL branch_ctrl got %b want 11111", {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush}); end
    tick();
    idle(); #1;
    checks++; if (muldiv_busy !== 0) begin errors++; $display("FAIL branch_no_start busy %b want 0", muldiv_busy); end
    checks++; if (flush_events !== f0 + 1 || stall_cycles !== s0) begin
      errors++; $display("FAIL branch_count flush %0d stall %0d want %0d %0d", flush_events, stall_cycles, f0 + 1, s0); end
    tick();
  endtask

  task automatic test_jump_and_freeze();
    logic [CNT_W-1:0] f0, s0;
    idle(); id_Jump = 1; #1;
    checks++; if ({pc_we, if_id_flush, id_ex_flush, ex_mem_flush} !== 4'b1100) begin
      errors++; $display("FAIL jump_ctrl got %b want 1100", {pc_we, if_id_flush, id_ex_flush, ex_mem_flush}); end
    tick();
    f0 = m_flush; s0 = m_stall;
    idle(); en = 0; id_Jump = 1; ex_muldiv_start = 1; #1;
    checks++; if ({pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush} !== 5'b00000) begin
      errors++; $display("FAIL freeze_ctrl got %b want 00000", {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush}); end
    tick(); #1;
    checks++; if (stall_cycles !== s0 || flush_events !== f0 || muldiv_busy !== 0) begin
      errors++; $display("FAIL freeze_hold stall %0d flush %0d busy %b want %0d %0d 0", stall_cycles, flush_events, muldiv_busy, s0, f0); end
    idle(); tick();
  endtask

  task automatic test_reset_mid_divide();
    idle(); ex_muldiv_start = 1; ex_is_div = 1; tick();
    idle(); id_uses_hilo = 1;
    for (int i = 0; i < 9; i++) tick();
    #2; reset_n = 0; #1;
    pend = 0; m_stall = '0; m_flush = '0;
    checks++; if (muldiv_busy !== 0 || stall_cycles !== 0 || flush_events !== 0 || pc_we !== 1) begin
      errors++; $display("FAIL rst_mid_div busy %b stall %0d flush %0d pc_we %b want 0 0 0 1", muldiv_busy, stall_cycles, flush_events, pc_we); end
    @(negedge clk); reset_n = 1; #1;
    checks++; if (muldiv_busy !== 0 || pc_we !== 1 || if_id_we !== 1) begin
      errors++; $display("FAIL rst_release busy %b pc_we %b if_id_we %b want 0 1 1", muldiv_busy, pc_we, if_id_we); end
    idle(); tick();
  endtask

  task automatic test_random();
    logic [4:0] c;
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 9) != 0);
      id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_uses_hilo = ($urandom_range(0, 3) == 0); id_Jump = ($urandom_range(0, 4) == 0);
      ex_rs_addr = 5'($urandom_range(0, 3)); ex_rt_addr = 5'($urandom_range(0, 3));
      ex_MemRead = ($urandom_range(0, 2) == 0); ex_Regs_waddr = 5'($urandom_range(0, 3));
      ex_muldiv_start = (pend == 0) && ($urandom_range(0, 7) == 0);
      ex_is_div = ($urandom_range(0, 3) == 0);
      mem_RegWrite = 1'($urandom); mem_Regs_waddr = 5'($urandom_range(0, 3));
      mem_Zero_Branch = ($urandom_range(0, 5) == 0);
      wb_RegWrite = 1'($urandom); wb_Regs_waddr = 5'($urandom_range(0, 3));
      #1;
      c = m_ctrl();
      checks++; if ({pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush} !== c) begin
        errors++; $display("FAIL rand_ctrl n=%0d got %b want %b", n, {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush}, c); end
      checks++; if (fwd_a !== m_fwd(ex_rs_addr) || fwd_b !== m_fwd(ex_rt_addr)) begin
        errors++; $display("FAIL rand_fwd n=%0d got %b/%b want %b/%b", n, fwd_a, fwd_b, m_fwd(ex_rs_addr), m_fwd(ex_rt_addr)); end
      checks++; if (muldiv_busy !== (pend > 0) || stall_cycles !== m_stall || flush_events !== m_flush) begin
        errors++; $display("FAIL rand_state n=%0d busy %b stall %0d flush %0d want %b %0d %0d", n, muldiv_busy, stall_cycles, flush_events, pend > 0, m_stall, m_flush); end
      tick();
    end
    idle();
  endtask

  initial begin
    idle(); reset_n = 0;
    @(negedge clk);
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_divide();
    test_branch();
    test_jump_and_freeze();
    test_reset_mid_divide();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
